// File: rtl/sprite_blitter.sv
// Sprite blitter: draws one 16x16 monochrome sprite from an internal ROM into a
// framebuffer as a stream of per-pixel writes, with clipping and three draw modes.
module sprite_blitter #(
    parameter int FB_W = 320,
    parameter int FB_H = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [8:0] req_x,
    input  logic [7:0] req_y,
    input  logic [1:0] req_sprite,
    input  logic [1:0] req_mode,
    output logic       do_write,
    output logic [8:0] write_x,
    output logic [7:0] write_y,
    output logic       write,
    output logic       busy,
    output logic       done,
    output logic [1:0] dbg_state
);

    // Request handshake: a request is taken on a rising edge where req_valid and
    // req_ready are both high; req_ready is high only in IDLE and req_* are
    // ignored at every other time.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [9:0] FB_W_L = 10'(FB_W);
    localparam logic [9:0] FB_H_L = 10'(FB_H);

    localparam logic [1:0] MODE_TRANSPARENT = 2'd1;
    localparam logic [1:0] MODE_ERASE       = 2'd2;

    state_t      state;
    state_t      state_nxt;
    logic [8:0]  x_q;
    logic [7:0]  y_q;
    logic [1:0]  sprite_q;
    logic [1:0]  mode_q;
    logic [3:0]  row_q;
    logic [3:0]  col_q;
    logic [15:0] rom_q;

    logic [9:0]  px;
    logic [9:0]  py;
    logic        in_bounds;
    logic        rom_bit;

    // Row word for a sprite; bit 15 is the leftmost column.
    function automatic logic [15:0] rom_row(input logic [1:0] s, input logic [3:0] r);
        logic [15:0] w;
        w = 16'h0000;
        case (s)
            2'd0: if (r[3]) w = 16'hFFF0;
            2'd1: if (r[3]) w = 16'hFFE0;
            2'd2: if (r[3]) w = 16'hFF00;
            default: begin
                if (r >= 4'd12)
                    w = 16'hFFF8;
                else if (r == 4'd10 || r == 4'd11)
                    w = 16'h0700;
            end
        endcase
        return w;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            sprite_q <= '0;
            mode_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            rom_q    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        x_q      <= req_x;
                        y_q      <= req_y;
                        sprite_q <= req_sprite;
                        mode_q   <= req_mode;
                        row_q    <= '0;
                        col_q    <= '0;
                    end
                end
                FETCH: begin
                    rom_q <= rom_row(sprite_q, row_q);
                    col_q <= '0;
                end
                DRAW: begin
                    col_q <= col_q + 4'd1;
                    if (col_q == 4'd15)
                        row_q <= row_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Coordinates are formed at 10 bits so a sprite hanging off the right or
    // bottom edge clips instead of wrapping back onto the framebuffer.
    always_comb begin
        px        = {1'b0, x_q} + {6'd0, col_q};
        py        = {2'b00, y_q} + {6'd0, row_q};
        in_bounds = (px < FB_W_L) && (py < FB_H_L);
        rom_bit   = rom_q[4'd15 - col_q];
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        do_write  = 1'b0;
        write_x   = '0;
        write_y   = '0;
        write     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = rst_n;
                if (req_valid)
                    state_nxt = FETCH;
            end
            FETCH: state_nxt = DRAW;
            DRAW: begin
                write_x = px[8:0];
                write_y = py[7:0];
                if (in_bounds) begin
                    case (mode_q)
                        MODE_TRANSPARENT: begin
                            do_write = rom_bit;
                            write    = 1'b1;
                        end
                        MODE_ERASE: begin
                            do_write = rom_bit;
                            write    = 1'b0;
                        end
                        default: begin
                            do_write = 1'b1;
                            write    = rom_bit;
                        end
                    endcase
                end
                if (col_q == 4'd15)
                    state_nxt = (row_q == 4'd15) ? DONE : FETCH;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: directed and random sprites compared
// against a rectangle-rule model of the sprite shapes, clipping and draw modes.
module tb_sprite_blitter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [8:0] req_x;
    logic [7:0] req_y;
    logic [1:0] req_sprite;
    logic [1:0] req_mode;
    logic       do_write;
    logic [8:0] write_x;
    logic [7:0] write_y;
    logic       write;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [17:0] exp_q[$];

    sprite_blitter #(.FB_W(320), .FB_H(200)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_sprite (req_sprite),
        .req_mode   (req_mode),
        .do_write   (do_write),
        .write_x    (write_x),
        .write_y    (write_y),
        .write      (write),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sprite shapes described as filled rectangles.
    function automatic bit sprite_bit(input int s, input int r, input int c);
        case (s)
            0: return (r >= 8) && (c <= 11);
            1: return (r >= 8) && (c <= 10);
            2: return (r >= 8) && (c <= 7);
            default: return ((r >= 12) && (c <= 12)) ||
                            ((r >= 10) && (r <= 11) && (c >= 5) && (c <= 7));
        endcase
    endfunction

    // Expected write stream in raster order: {x[8:0], y[7:0], value}.
    task automatic build_expected(input int x, input int y, input int s, input int m);
        exp_q.delete();
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                int  px;
                int  py;
                bit  b;
                logic [8:0] wx;
                logic [7:0] wy;
                px = x + c;
                py = y + r;
                b  = sprite_bit(s, r, c);
                wx = px[8:0];
                wy = py[7:0];
                if (px < 320 && py < 200) begin
                    if (m == 1) begin
                        if (b) exp_q.push_back({wx, wy, 1'b1});
                    end else if (m == 2) begin
                        if (b) exp_q.push_back({wx, wy, 1'b0});
                    end else begin
                        exp_q.push_back({wx, wy, b});
                    end
                end
            end
        end
    endtask

    // Called away from the rising edge; returns just after the handshake edge.
    task automatic start_req(input int x, input int y, input int s, input int m);
        int w;
        req_x      = 9'(x);
        req_y      = 8'(y);
        req_sprite = 2'(s);
        req_mode   = 2'(m);
        req_valid  = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("handshake_ready", req_ready, 1);
        @(posedge clk);
    endtask

    task automatic run_check(input string tag, input int exp_writes, input bit hold);
        int busy_cnt;
        int done_cnt;
        int done_at;
        int writes;
        int cyc;
        logic [17:0] e;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        writes   = 0;
        cyc      = 0;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (!busy) break;
            busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = busy_cnt;
            end
            if (do_write) begin
                writes++;
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_write"}, writes, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "_write"}, {14'd0, write_x, write_y, write}, {14'd0, e});
                end
            end
            req_valid  = hold ? 1'b1 : 1'($urandom_range(0, 1));
            req_x      = 9'($urandom_range(0, 511));
            req_y      = 8'($urandom_range(0, 255));
            req_sprite = 2'($urandom_range(0, 3));
            req_mode   = 2'($urandom_range(0, 3));
        end
        if (!hold) req_valid = 1'b0;
        check({tag, "_returned_idle"}, busy, 0);
        check({tag, "_busy_cycles"}, busy_cnt, 273);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_at, 273);
        if (exp_writes >= 0)
            check({tag, "_write_count"}, writes, exp_writes);
        check({tag, "_missing_writes"}, exp_q.size(), 0);
        check({tag, "_idle_ready"}, req_ready, 1);
        check({tag, "_idle_outputs"}, {do_write, write_x, write_y, write, done}, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_x      = '0;
        req_y      = '0;
        req_sprite = '0;
        req_mode   = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {req_ready, do_write, write_x, write_y, write, busy, done}, 0);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", req_ready, 1);
        check("idle_not_busy", busy, 0);

        build_expected(10, 20, 2, 0);
        start_req(10, 20, 2, 0);
        run_check("opaque_s2", 256, 0);

        build_expected(0, 0, 0, 1);
        start_req(0, 0, 0, 1);
        run_check("transp_s0", 96, 0);

        build_expected(100, 150, 3, 2);
        start_req(100, 150, 3, 2);
        run_check("erase_s3", 58, 0);

        build_expected(310, 190, 1, 0);
        start_req(310, 190, 1, 0);
        run_check("clip_s1", 100, 0);

        build_expected(50, 60, 1, 1);
        start_req(50, 60, 1, 1);
        run_check("cont_a", 88, 1);
        build_expected(200, 100, 3, 2);
        start_req(200, 100, 3, 2);
        run_check("cont_b", 58, 0);

        for (int i = 0; i < 6; i++) begin
            int x;
            int y;
            int s;
            int m;
            x = int'($urandom_range(0, 511));
            y = int'($urandom_range(0, 255));
            s = int'($urandom_range(0, 3));
            m = int'($urandom_range(0, 3));
            build_expected(x, y, s, m);
            start_req(x, y, s, m);
            run_check("random", -1, 0);
        end

        start_req(0, 0, 0, 0);
        repeat (20) @(negedge clk);
        check("pre_reset_write", do_write, 1);
        check("pre_reset_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_write", do_write, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_ready", req_ready, 0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_ready", req_ready, 1);
        check("post_reset_busy", busy, 0);
        @(negedge clk);
        check("abandoned_not_resumed", busy, 0);

        build_expected(305, 195, 0, 3);
        start_req(305, 195, 0, 3);
        run_check("after_reset", -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
